// File: rtl/hangman_main.sv
// Single-clock core of a two-keypad hangman game. Both multi-tap pads are
// debounced, the pad selected by role_switch drives the game FSM, and the
// LCD images and LEDs are decoded from registered state.

// One pad: a one-hot row that is stable for DEBOUNCE cycles produces one
// key event. The next press is accepted only after the row has read zero
// for DEBOUNCE cycles.
module hangman_debounce #(
  parameter int DEBOUNCE = 1000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] row,
  output logic       ev_valid,
  output logic [3:0] ev_key
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [3:0]    last;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          stable;
  logic          one_hot;

  assign stable  = (row == last) && (cnt == CNT_MAX);
  assign one_hot = (row != 4'd0) && ((row & (row - 4'd1)) == 4'd0);

  // Track row stability and fire a single event per press.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      last     <= 4'd0;
      cnt      <= '0;
      armed    <= 1'b1;
      ev_valid <= 1'b0;
      ev_key   <= 4'd0;
    end else begin
      ev_valid <= 1'b0;
      if (row != last) begin
        last <= row;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (armed && stable && one_hot) begin
        ev_valid <= 1'b1;
        ev_key   <= row;
        armed    <= 1'b0;
      end else if (!armed && stable && (row == 4'd0)) begin
        armed <= 1'b1;
      end
    end
  end
endmodule

module hangman_main #(
  parameter int DEBOUNCE = 1000,
  parameter int MAX_LEN  = 8,
  parameter int MAX_MISS = 6
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         role_switch,
  input  logic [3:0]   input_row_host,
  input  logic [3:0]   input_row_player,
  output logic [127:0] host_row1,
  output logic [127:0] host_row2,
  output logic [127:0] play_row1,
  output logic [127:0] play_row2,
  output logic         red,
  output logic         green,
  output logic         blue,
  output logic         error,
  output logic         msg_sent
);
  localparam logic [1:0] S_SETUP = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_WIN   = 2'd2;
  localparam logic [1:0] S_LOSE  = 2'd3;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int MW = $clog2(MAX_MISS + 1);

  // Letters are held as 5-bit codes (A=0 .. Z=25).
  function automatic logic [4:0] code_of(input logic [1:0] g, input logic [2:0] p);
    case (g)
      2'd3: case (p)
              3'd0:    code_of = 5'd0;   // A
              3'd1:    code_of = 5'd4;   // E
              3'd2:    code_of = 5'd8;   // I
              3'd3:    code_of = 5'd14;  // O
              default: code_of = 5'd20;  // U
            endcase
      2'd2:    code_of = 5'd9 + {2'b00, p};   // J K L
      default: code_of = 5'd15 + {2'b00, p};  // P Q R S
    endcase
  endfunction

  function automatic logic [2:0] grp_last(input logic [1:0] g);
    case (g)
      2'd3:    grp_last = 3'd4;
      2'd2:    grp_last = 3'd2;
      default: grp_last = 3'd3;
    endcase
  endfunction

  logic          h_ev, p_ev;
  logic [3:0]    h_key, p_key;
  logic [1:0]    state;
  logic [4:0]    word [MAX_LEN];
  logic [LW-1:0] len;
  logic [25:0]   guessed;
  logic [MW-1:0] miss;
  logic          pend_valid;
  logic [1:0]    pend_grp;
  logic [2:0]    pend_pos;

  logic          game_ev;
  logic [3:0]    key;
  logic [1:0]    key_grp;
  logic [2:0]    tap_pos;
  logic [4:0]    pend_code;
  logic [25:0]   guessed_next;
  logic          in_word;
  logic          all_hit;
  logic [7:0]    pend_ascii;

  hangman_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_host (
    .clk(clk), .nRst(nRst), .row(input_row_host), .ev_valid(h_ev), .ev_key(h_key)
  );
  hangman_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_player (
    .clk(clk), .nRst(nRst), .row(input_row_player), .ev_valid(p_ev), .ev_key(p_key)
  );

  // Pick the event of the pad that the current state listens to.
  // NOTE: every signal written in a combinational block gets a default
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    key     = role_switch ? p_key : h_key;
    game_ev = 1'b0;
    if (state == S_PLAY) game_ev = p_ev && role_switch;
    else                 game_ev = h_ev && !role_switch;
    key_grp = key[3] ? 2'd3 : (key[2] ? 2'd2 : 2'd1);
    tap_pos = 3'd0;
    if (pend_valid && (pend_grp == key_grp) && (pend_pos != grp_last(key_grp)))
      tap_pos = pend_pos + 3'd1;
  end

  // Evaluate the pending letter against the word.
  always_comb begin
    pend_code    = code_of(pend_grp, pend_pos);
    guessed_next = guessed | (26'd1 << pend_code);
    in_word      = 1'b0;
    all_hit      = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) begin
        if (word[i] == pend_code) in_word = 1'b1;
        if (!guessed_next[word[i]]) all_hit = 1'b0;
      end
    end
  end

  // Game FSM: multi-tap entry, word building, guessing and restart.
  // NOTE: the word store is small and is cleared by reset like any other
  // register, so display decoding never sees stale letters.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= S_SETUP;
      len        <= '0;
      guessed    <= '0;
      miss       <= '0;
      pend_valid <= 1'b0;
      pend_grp   <= 2'd0;
      pend_pos   <= 3'd0;
      error      <= 1'b0;
      msg_sent   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) word[i] <= 5'd0;
    end else begin
      error    <= 1'b0;
      msg_sent <= 1'b0;
      if (game_ev) begin
        if ((state == S_SETUP || state == S_PLAY) && !key[0]) begin
          pend_valid <= 1'b1;
          pend_grp   <= key_grp;
          pend_pos   <= tap_pos;
        end else if (key[0]) begin
          pend_valid <= 1'b0;
          case (state)
            S_SETUP: begin
              if (pend_valid) begin
                if (len == LW'(MAX_LEN)) error <= 1'b1;
                else begin
                  for (int i = 0; i < MAX_LEN; i++)
                    if (i == int'(len)) word[i] <= pend_code;
                  len <= len + 1'b1;
                end
              end else if (len == '0) begin
                error <= 1'b1;
              end else begin
                state    <= S_PLAY;
                msg_sent <= 1'b1;
              end
            end
            S_PLAY: begin
              if (pend_valid) begin
                if (guessed[pend_code]) error <= 1'b1;
                else begin
                  guessed  <= guessed_next;
                  msg_sent <= 1'b1;
                  if (!in_word) miss <= miss + 1'b1;
                  if (all_hit) state <= S_WIN;
                  else if (!in_word && (miss == MW'(MAX_MISS - 1))) state <= S_LOSE;
                end
              end
            end
            default: begin
              state   <= S_SETUP;
              len     <= '0;
              guessed <= '0;
              miss    <= '0;
              for (int i = 0; i < MAX_LEN; i++) word[i] <= 5'd0;
            end
          endcase
        end
      end
    end
  end

  assign blue  = (state == S_PLAY);
  assign green = (state == S_WIN);
  assign red   = (state == S_LOSE);

  // Decode the four LCD lines from registered state.
  always_comb begin
    pend_ascii = pend_valid ? (8'h41 + {3'b000, pend_code}) : 8'h20;
    host_row1  = {"WORD:", {11{" "}}};
    host_row2  = {"SENT", {12{" "}}};
    play_row1  = {16{" "}};
    play_row2  = {16{" "}};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) begin
        host_row1[127 - 8*(5 + i) -: 8] = 8'h41 + {3'b000, word[i]};
        play_row1[127 - 8*i -: 8] = guessed[word[i]] ? (8'h41 + {3'b000, word[i]}) : "_";
      end
    end
    case (state)
      S_SETUP: begin
        host_row2 = {"LETTER:", pend_ascii, {8{" "}}};
        play_row1 = {"WAITING", {9{" "}}};
      end
      S_PLAY:  play_row2 = {"MISS:", 8'h30 + 8'(miss), " GUESS:", pend_ascii, {2{" "}}};
      S_WIN:   play_row2 = {"YOU WIN", {9{" "}}};
      default: play_row2 = {"YOU LOSE", {8{" "}}};
    endcase
  end
endmodule

// File: tb/tb_hangman_main.sv
// Directed bench for hangman_main: keypad presses are driven as held rows,
// expected msg_sent/error pulses are queued and matched by a monitor, and
// LCD lines and LEDs are compared against hand-written strings.
module tb_hangman_main;
  localparam int DEB  = 8;
  localparam int HOLD = DEB + 6;
  localparam logic [3:0] K_VOW = 4'b1000;
  localparam logic [3:0] K_JKL = 4'b0100;
  localparam logic [3:0] K_PQR = 4'b0010;
  localparam logic [3:0] K_SUB = 4'b0001;

  typedef enum logic [1:0] {EXP_NONE = 2'b00, EXP_ERR = 2'b01, EXP_MSG = 2'b10} pulse_e;

  logic         tb_clk = 1'b0;
  logic         nRst;
  logic         role_switch;
  logic [3:0]   input_row_host;
  logic [3:0]   input_row_player;
  logic [127:0] host_row1, host_row2, play_row1, play_row2;
  logic         red, green, blue, error, msg_sent;

  pulse_e exp_q[$];
  pulse_e exp_now;
  int     n_checks = 0;
  int     n_fail   = 0;

  hangman_main #(.DEBOUNCE(DEB), .MAX_LEN(8), .MAX_MISS(6)) dut (
    .clk(tb_clk), .nRst(nRst), .role_switch(role_switch),
    .input_row_host(input_row_host), .input_row_player(input_row_player),
    .host_row1(host_row1), .host_row2(host_row2),
    .play_row1(play_row1), .play_row2(play_row2),
    .red(red), .green(green), .blue(blue), .error(error), .msg_sent(msg_sent)
  );

  always #5 tb_clk = ~tb_clk;

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge tb_clk) begin
    if (msg_sent || error) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pulse: got msg_sent=%b error=%b, required no pulse", msg_sent, error);
      end else begin
        exp_now = exp_q.pop_front();
        if ({msg_sent, error} != exp_now) begin
          n_fail++;
          $display("FAIL pulse: got msg_sent=%b error=%b, required %b", msg_sent, error, exp_now);
        end
      end
    end
  end

  function automatic logic [127:0] pad16(input string s);
    logic [127:0] r;
    r = {16{8'h20}};
    for (int i = 0; i < 16 && i < s.len(); i++) r[127 - 8*i -: 8] = s[i];
    return r;
  endfunction

  task automatic check_row(input string name, input logic [127:0] act, input string s);
    logic [127:0] exp;
    exp = pad16(s);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got '%s' required '%s'", name, act, exp);
    end
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic press(input bit player, input logic [3:0] k);
    if (player) input_row_player = k;
    else        input_row_host   = k;
    repeat (HOLD) @(negedge tb_clk);
    input_row_player = 4'd0;
    input_row_host   = 4'd0;
    repeat (HOLD) @(negedge tb_clk);
  endtask

  task automatic letter(input bit player, input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) press(player, k);
  endtask

  task automatic submit(input bit player, input pulse_e e);
    if (e != EXP_NONE) exp_q.push_back(e);
    press(player, K_SUB);
  endtask

  initial begin
    nRst = 1'b0; role_switch = 1'b0;
    input_row_host = 4'd0; input_row_player = 4'd0;
    repeat (3) @(negedge tb_clk);
    nRst = 1'b1;
    @(negedge tb_clk);
    check_row("reset host_row1", host_row1, "WORD:");
    check_row("reset play_row1", play_row1, "WAITING");
    check("reset leds", {red, green, blue}, 3'b000);

    // Multi-tap, then reset mid-entry.
    letter(0, K_VOW, 1);
    check_row("tap A", host_row2, "LETTER:A");
    letter(0, K_VOW, 1);
    check_row("tap E", host_row2, "LETTER:E");
    nRst = 1'b0;
    @(negedge tb_clk);
    check_row("midreset host_row2", host_row2, "LETTER:");
    check_row("midreset host_row1", host_row1, "WORD:");
    check("midreset leds", {red, green, blue}, 3'b000);
    check("midreset pulses", {1'b0, msg_sent, error}, 3'b000);
    nRst = 1'b1;
    @(negedge tb_clk);

    // Host enters APPLE.
    letter(0, K_VOW, 1); submit(0, EXP_NONE);
    letter(0, K_PQR, 1); submit(0, EXP_NONE);
    letter(0, K_PQR, 1); submit(0, EXP_NONE);
    letter(0, K_JKL, 3);
    check_row("tap L", host_row2, "LETTER:L");
    submit(0, EXP_NONE);
    letter(0, K_VOW, 2); submit(0, EXP_NONE);
    check_row("word apple", host_row1, "WORD:APPLE");
    check_row("setup play_row1", play_row1, "WAITING");
    submit(0, EXP_MSG);
    check("play leds", {red, green, blue}, 3'b001);
    check_row("play blanks", play_row1, "_____");
    check_row("play host_row2", host_row2, "SENT");
    check_row("play row2 start", play_row2, "MISS:0 GUESS:");

    // Player guesses.
    role_switch = 1'b1;
    letter(1, K_PQR, 1);
    check_row("guess P pending", play_row2, "MISS:0 GUESS:P");
    submit(1, EXP_MSG);
    check_row("after P", play_row1, "_PP__");
    letter(1, K_PQR, 1); submit(1, EXP_ERR);
    check_row("repeat P row2", play_row2, "MISS:0 GUESS:");
    check_row("repeat P row1", play_row1, "_PP__");
    letter(1, K_JKL, 3); submit(1, EXP_MSG);
    check_row("after L", play_row1, "_PPL_");
    letter(1, K_VOW, 3); submit(1, EXP_MSG);
    check_row("miss I", play_row2, "MISS:1 GUESS:");
    letter(1, K_JKL, 4);
    check_row("wrap J", play_row2, "MISS:1 GUESS:J");
    letter(1, K_VOW, 1);
    check_row("group switch A", play_row2, "MISS:1 GUESS:A");
    submit(1, EXP_MSG);
    check_row("after A", play_row1, "APPL_");
    letter(1, K_VOW, 2); submit(1, EXP_MSG);
    check("win leds", {red, green, blue}, 3'b010);
    check_row("win row2", play_row2, "YOU WIN");
    check_row("win row1", play_row1, "APPLE");
    letter(1, K_VOW, 1); submit(1, EXP_NONE);
    check("win ignores player", {red, green, blue}, 3'b010);
    role_switch = 1'b0;
    submit(0, EXP_NONE);
    check("restart leds", {red, green, blue}, 3'b000);
    check_row("restart host_row1", host_row1, "WORD:");
    check_row("restart play_row1", play_row1, "WAITING");

    // Word PL, six wrong guesses.
    letter(0, K_PQR, 1); submit(0, EXP_NONE);
    letter(0, K_JKL, 3); submit(0, EXP_NONE);
    submit(0, EXP_MSG);
    role_switch = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      letter(1, K_VOW, v); submit(1, EXP_MSG);
    end
    check_row("miss 5", play_row2, "MISS:5 GUESS:");
    check("miss 5 leds", {red, green, blue}, 3'b001);
    letter(1, K_JKL, 1); submit(1, EXP_MSG);
    check("lose leds", {red, green, blue}, 3'b100);
    check_row("lose row2", play_row2, "YOU LOSE");
    check_row("lose row1", play_row1, "__");
    role_switch = 1'b0;
    submit(0, EXP_NONE);
    check("lose restart leds", {red, green, blue}, 3'b000);
    check_row("lose restart row1", host_row1, "WORD:");

    // Inactive host pad, empty word, full word.
    role_switch = 1'b1;
    letter(0, K_VOW, 1); submit(0, EXP_NONE);
    check_row("inactive host row1", host_row1, "WORD:");
    check_row("inactive host row2", host_row2, "LETTER:");
    role_switch = 1'b0;
    submit(0, EXP_ERR);
    check("empty word leds", {red, green, blue}, 3'b000);
    for (int i = 0; i < 8; i++) begin
      letter(0, K_VOW, 1); submit(0, EXP_NONE);
    end
    check_row("full word", host_row1, "WORD:AAAAAAAA");
    letter(0, K_JKL, 1); submit(0, EXP_ERR);
    check_row("overflow dropped", host_row1, "WORD:AAAAAAAA");
    submit(0, EXP_MSG);
    check("full word play", {red, green, blue}, 3'b001);
    check_row("full word blanks", play_row1, "________");

    repeat (20) @(negedge tb_clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pulse queue: got %0d pulses still outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
